axi_lite_timer: RTL and testbench

AXI_LITE_TIMER -- requirements
Module: axi_lite_timer

---
 rtl/axi_lite_timer.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_lite_timer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_timer.sv
// AXI4-Lite slave timer: 32-bit up-counter with compare match, STATUS flag and registered interrupt.
// Defining TIMER_PRESCALER_EN adds an 8-bit PRESCALE register at 0x10 that divides the count tick.
module axi_lite_timer #(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  output logic [1:0]  S_AXI_BRESP,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [1:0]  S_AXI_RRESP,
  output logic        irq_o
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] IDX_CTRL    = IW'(0);
  localparam logic [IW-1:0] IDX_COMPARE = IW'(1);
  localparam logic [IW-1:0] IDX_COUNT   = IW'(2);
  localparam logic [IW-1:0] IDX_STATUS  = IW'(3);
  localparam logic [IW-1:0] IDX_PRESC   = IW'(4);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  w_state_t    w_state_q, w_state_d;
  r_state_t    r_state_q, r_state_d;
  logic        wrdy_q, wrdy_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic        arrdy_q, arrdy_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] compare_q, compare_d, count_q, count_d;
  logic        match_q, match_d, irq_q;
  logic [IW-1:0] widx, ridx;
  logic        wr_fire, rd_fire, tick, hit;
`ifdef TIMER_PRESCALER_EN
  logic [7:0]  presc_q, presc_d, div_q, div_d;
  logic        presc_wr;
`endif
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_AWADDR[31:ADDR_W], S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[31:ADDR_W], S_AXI_ARADDR[1:0]};

  function automatic logic is_mapped(input logic [IW-1:0] idx);
`ifdef TIMER_PRESCALER_EN
    is_mapped = (idx <= IDX_PRESC);
`else
    is_mapped = (idx <= IDX_STATUS);
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    merge = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merge[8*b +: 8] = nw[8*b +: 8];
    end
  endfunction

  assign widx    = S_AXI_AWADDR[ADDR_W-1:2];
  assign ridx    = S_AXI_ARADDR[ADDR_W-1:2];
  // Handshake: a channel transfers on the edge where its VALID and READY are both high;
  // AW and W are only ever accepted together, and READY is a registered one-cycle pulse.
  assign wr_fire = (w_state_q == W_IDLE) && wrdy_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = (r_state_q == R_IDLE) && arrdy_q && S_AXI_ARVALID;

  always_comb begin
    w_state_d = w_state_q;
    wrdy_d    = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        wrdy_d = !wrdy_q && S_AXI_AWVALID && S_AXI_WVALID;
        if (wr_fire) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = is_mapped(widx) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (ridx)
      IDX_CTRL:    rd_val = {29'd0, ctrl_q};
      IDX_COMPARE: rd_val = compare_q;
      IDX_COUNT:   rd_val = count_q;
      IDX_STATUS:  rd_val = {31'd0, match_q};
`ifdef TIMER_PRESCALER_EN
      IDX_PRESC:   rd_val = {24'd0, presc_q};
`endif
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arrdy_d   = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arrdy_d = !arrdy_q && S_AXI_ARVALID;
        if (rd_fire) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = is_mapped(ridx) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
    endcase
  end

`ifdef TIMER_PRESCALER_EN
  assign tick = ctrl_q[0] && (div_q == presc_q);
  assign div_d = (!ctrl_q[0] || presc_wr || tick) ? 8'd0 : div_q + 8'd1;
`else
  assign tick = ctrl_q[0];
`endif

  // Register writes are applied after the tick update so a COUNT write overrides it,
  // and the match set is applied after the STATUS clear so a simultaneous set wins.
  always_comb begin
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    count_d   = count_q;
    match_d   = match_q;
    hit       = tick && (count_q == compare_q);
`ifdef TIMER_PRESCALER_EN
    presc_d   = presc_q;
    presc_wr  = 1'b0;
`endif
    if (tick) count_d = (hit && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;
    if (wr_fire) begin
      case (widx)
        IDX_CTRL:    if (S_AXI_WSTRB[0]) ctrl_d = S_AXI_WDATA[2:0];
        IDX_COMPARE: compare_d = merge(compare_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_COUNT:   count_d = merge(count_q, S_AXI_WDATA, S_AXI_WSTRB);
        IDX_STATUS:  if (S_AXI_WSTRB[0] && S_AXI_WDATA[0]) match_d = 1'b0;
`ifdef TIMER_PRESCALER_EN
        IDX_PRESC: begin
          if (S_AXI_WSTRB[0]) presc_d = S_AXI_WDATA[7:0];
          presc_wr = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    if (hit) match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wrdy_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arrdy_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      ctrl_q    <= '0;
      compare_q <= RST_COMPARE;
      count_q   <= '0;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      presc_q   <= '0;
      div_q     <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wrdy_q    <= wrdy_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arrdy_q   <= arrdy_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      ctrl_q    <= ctrl_d;
      compare_q <= compare_d;
      count_q   <= count_d;
      match_q   <= match_d;
      irq_q     <= match_q & ctrl_q[1];
`ifdef TIMER_PRESCALER_EN
      presc_q   <= presc_d;
      div_q     <= div_d;
`endif
    end
  end

  assign S_AXI_AWREADY = wrdy_q;
  assign S_AXI_WREADY  = wrdy_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arrdy_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_axi_lite_timer.sv
// Bench for axi_lite_timer: directed + randomized AXI-Lite traffic checked against a
// cycle-level behavioural model of the register map and timer rules.
module tb_axi_lite_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, irq;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_timer #(.ADDR_W(12), .RST_COMPARE(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RRESP(rresp),
    .irq_o(irq)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_compare, m_count;
  logic        m_match, m_irq;
  logic [7:0]  m_presc, m_div;
  logic        m_wr;
  logic [31:0] m_waddr, m_wdata;
  logic [3:0]  m_wstrb;

  task automatic model_reset();
    m_ctrl = 3'd0; m_compare = 32'hFFFF_FFFF; m_count = 32'd0;
    m_match = 1'b0; m_irq = 1'b0; m_presc = 8'd0; m_div = 8'd0; m_wr = 1'b0;
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  always @(posedge clk) begin
    if (rst) begin : model_step
      logic        t, h, nmatch;
      logic [31:0] ncount;
      logic [9:0]  idx;
      t = m_ctrl[0];
`ifdef TIMER_PRESCALER_EN
      t = m_ctrl[0] && (m_div == m_presc);
      m_div = (!m_ctrl[0] || t) ? 8'd0 : m_div + 8'd1;
`endif
      h = t && (m_count == m_compare);
      m_irq = m_match & m_ctrl[1];
      ncount = !t ? m_count : ((h && m_ctrl[2]) ? 32'd0 : m_count + 32'd1);
      nmatch = m_match;
      if (m_wr) begin
        idx = m_waddr[11:2];
        case (idx)
          10'd0: if (m_wstrb[0]) m_ctrl = m_wdata[2:0];
          10'd1: m_compare = byte_merge(m_compare, m_wdata, m_wstrb);
          10'd2: ncount = byte_merge(m_count, m_wdata, m_wstrb);
          10'd3: if (m_wstrb[0] && m_wdata[0]) nmatch = 1'b0;
`ifdef TIMER_PRESCALER_EN
          10'd4: begin
            if (m_wstrb[0]) m_presc = m_wdata[7:0];
            m_div = 8'd0;
          end
`endif
          default: ;
        endcase
      end
      if (h) nmatch = 1'b1;
      m_count = ncount;
      m_match = nmatch;
    end
  end

  function automatic logic addr_mapped(input logic [31:0] addr);
`ifdef TIMER_PRESCALER_EN
    return addr[11:2] <= 10'd4;
`else
    return addr[11:2] <= 10'd3;
`endif
  endfunction

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] d,
                                     output logic [1:0] r);
    logic [9:0] idx;
    idx = addr[11:2];
    d = 32'd0;
    r = addr_mapped(addr) ? 2'b00 : 2'b10;
    case (idx)
      10'd0: d = {29'd0, m_ctrl};
      10'd1: d = m_compare;
      10'd2: d = m_count;
      10'd3: d = {31'd0, m_match};
`ifdef TIMER_PRESCALER_EN
      10'd4: d = {24'd0, m_presc};
`endif
      default: d = 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk({tag, "_awready"}, 32'(awready), 32'd1);
    chk({tag, "_wready"}, 32'(wready), 32'd1);
    m_waddr = addr; m_wdata = data; m_wstrb = strb; m_wr = 1'b1;
    @(negedge clk);
    m_wr = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(bresp), addr_mapped(addr) ? 32'd0 : 32'd2);
  endtask

  task automatic axi_read(input logic [31:0] addr, input string tag);
    logic [31:0] ed;
    logic [1:0]  er;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    @(negedge clk);
    chk({tag, "_arready"}, 32'(arready), 32'd1);
    model_read(addr, ed, er);
    exp_q.push_back(ed);
    exp_q.push_back(32'(er));
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"}, rdata, exp_q.pop_front());
    chk({tag, "_rresp"}, 32'(rresp), exp_q.pop_front());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_wready"}, 32'(wready), 32'd0);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_bresp"}, 32'(bresp), 32'd0);
    chk({tag, "_rresp"}, 32'(rresp), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    int guard;
    // clock/reset: valids held high during reset must not be accepted
    rst = 1'b0; model_reset();
    awaddr = 32'h4; wdata = 32'h0; wstrb = 4'hF; araddr = 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    axi_read(32'h4, "cmp_rst");
    axi_read(32'h8, "cnt_rst");
    axi_read(32'h0, "ctrl_rst");
    axi_read(32'hC, "status_rst");

    // random COMPARE byte-lane writes with the timer stopped
    for (int i = 0; i < 6; i++) begin
      axi_write(32'h4, $urandom, 4'($urandom_range(1, 15)), "cmp_rand");
      axi_read({20'($urandom), 12'h004}, "cmp_rand_rd");
    end
    axi_write(32'h0, $urandom & 32'hFFFF_FFF8, 4'hF, "ctrl_rsvd");
    axi_read(32'h0, "ctrl_rsvd_rd");

    // byte strobe into a cleared COMPARE
    axi_write(32'h4, 32'h0, 4'hF, "cmp_zero");
    axi_write(32'h4, 32'hAABB_CCDD, 4'b0010, "cmp_strb");
    axi_read(32'h4, "cmp_strb_rd");

    // write-response backpressure; a second write held on the bus must wait
    bready = 1'b0;
    @(negedge clk);
    awaddr = 32'h4; wdata = 32'h0000_0011; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("bp_awready", 32'(awready), 32'd1);
    m_waddr = 32'h4; m_wdata = 32'h0000_0011; m_wstrb = 4'hF; m_wr = 1'b1;
    @(negedge clk);
    m_wr = 1'b0; wdata = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_bresp", 32'(bresp), 32'd0);
      chk("bp_no_accept", 32'(awready | wready), 32'd0);
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("bp_bvalid_done", 32'(bvalid), 32'd0);
    axi_read(32'h4, "bp_cmp_rd");

    // auto-clear counting with interrupt
    axi_write(32'h8, 32'h0, 4'hF, "cnt_zero");
    axi_write(32'h4, 32'd5, 4'hF, "cmp5");
    axi_write(32'h0, 32'h7, 4'hF, "ctrl7");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("irq_auto", 32'(irq), 32'(m_irq));
    end
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      axi_read(32'h8, "cnt_auto");
    end
    axi_read(32'hC, "status_auto");

    // STATUS clear landing on a match edge: match must survive
    guard = 0;
    while (m_count != 32'd3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    axi_write(32'hC, 32'h1, 4'hF, "clr_on_match");
    axi_read(32'hC, "status_set_wins");
    axi_write(32'h0, 32'h2, 4'hF, "ctrl_stop");
    axi_write(32'hC, 32'h1, 4'hF, "clr_idle");
    chk("irq_clr_t0", 32'(irq), 32'(m_irq));
    @(negedge clk);
    chk("irq_clr_t1", 32'(irq), 32'(m_irq));
    axi_read(32'hC, "status_cleared");

    // wrap through 0xFFFF_FFFF, no auto-clear; COUNT write races a tick
    axi_write(32'h0, 32'h0, 4'hF, "ctrl_off");
    axi_write(32'h4, 32'd3, 4'hF, "cmp3");
    axi_write(32'h0, 32'h1, 4'hF, "ctrl_en");
    axi_write(32'h8, 32'hFFFF_FFFF, 4'hF, "cnt_max");
    axi_read(32'h8, "cnt_wrap");
    axi_read(32'hC, "status_wrap");
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      axi_read(32'h8, "cnt_free");
    end
    axi_read(32'hC, "status_free");

    // unmapped offsets
    axi_read(32'h14, "unmapped_14");
    axi_write(32'h14, $urandom, 4'hF, "unmapped_wr");
    for (int i = 0; i < 4; i++)
      axi_read({20'($urandom), 10'($urandom_range(5, 1023)), 2'($urandom)}, "unmapped_rand");

`ifdef TIMER_PRESCALER_EN
    axi_write(32'h0, 32'h0, 4'hF, "pre_off");
    axi_write(32'h10, 32'd3, 4'hF, "pre_wr");
    axi_write(32'h8, 32'h0, 4'hF, "pre_cnt0");
    axi_write(32'h0, 32'h1, 4'hF, "pre_en");
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      axi_read(32'h8, "pre_cnt");
    end
    axi_read(32'h10, "pre_rd");
`else
    axi_write(32'h10, 32'd3, 4'hF, "pre_absent_wr");
    axi_read(32'h10, "pre_absent_rd");
`endif

    // reset in the middle of an accepted write: no response afterwards
    @(negedge clk);
    awaddr = 32'h4; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0; model_reset();
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_b", 32'(bvalid), 32'd0);
    end
    axi_read(32'h4, "midrst_cmp");
    axi_read(32'h0, "midrst_ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
